// File: rtl/decomp_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decomp_stream_ctrl
// Description : Streams 256-coefficient polynomials from a source RAM through
//               the coefficient decomposer. Writes the a0/a1 results to a
//               destination RAM port at the same address offset.
// Revision    : 1.0 - initial release
// ============================================================================
module decomp_stream_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int N_COEFF  = 256,
    parameter int MAX_POLY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        sec_lvl,
    input  logic [3:0]        poly_cnt,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic [2:0]        dec_sec_lvl,
    output logic [23:0]       dec_di,
    output logic              dec_valid_i,
    input  logic              dec_ready_i,
    input  logic [23:0]       dec_doa,
    input  logic [23:0]       dec_dob,
    input  logic              dec_valid_o,
    output logic              dec_ready_o,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_a0,
    output logic [5:0]        wr_a1,
    input  logic              wr_ready
);

    // Coefficient counters are wide enough for MAX_POLY * N_COEFF = 2048.
    localparam int         CNT_W      = 12;
    localparam int         FIFO_DEPTH = 2;
    localparam logic [3:0] MAX_POLY_C = 4'(MAX_POLY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [2:0]        sec_lvl_q,   sec_lvl_d;
    logic [CNT_W-1:0]  total_q,     total_d;
    logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;
    logic [ADDR_W-1:0] rd_base_q,   rd_base_d;
    logic [ADDR_W-1:0] wr_base_q,   wr_base_d;
    logic              pending_q,   pending_d;
    logic [23:0]       fifo_mem_q [FIFO_DEPTH];
    logic [23:0]       fifo_mem_d [FIFO_DEPTH];
    logic              fifo_wptr_q, fifo_wptr_d;
    logic              fifo_rptr_q, fifo_rptr_d;
    logic [1:0]        fifo_cnt_q,  fifo_cnt_d;

    logic              cfg_bad;
    logic [CNT_W-1:0]  req_total;
    logic              push;
    logic              pop;
    logic [2:0]        rd_room;
    logic              wr_fire;
    logic              unused_dob_hi;

    // Only the low six bits of the decomposer's a1 output carry information.
    assign unused_dob_hi = ^dec_dob[23:6];

    // Configuration checks evaluated against the live start inputs.
    always_comb begin
        cfg_bad   = (poly_cnt == 4'd0) || (poly_cnt > MAX_POLY_C);
        req_total = CNT_W'(poly_cnt) * CNT_W'(N_COEFF);
    end

    // Handshake, address and status outputs.
    always_comb begin
        busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        dec_sec_lvl = sec_lvl_q;
        dec_valid_i = (fifo_cnt_q != 2'd0);
        dec_di      = fifo_mem_q[fifo_rptr_q];
        pop         = dec_valid_i & dec_ready_i;
        push        = pending_q;
        // Entries the FIFO will hold once the in-flight read lands and the
        // current pop retires; a new read is only allowed if this stays < 2.
        rd_room     = {1'b0, fifo_cnt_q} + {2'b00, pending_q} - {2'b00, pop};
        rd_en       = (state_q == S_RUN) && (rd_cnt_q < total_q) && (rd_room < 3'd2);
        rd_addr     = rd_base_q + ADDR_W'(rd_cnt_q);
        dec_ready_o = wr_ready;
        // The count guard keeps stale decomposer output from being written
        // when a rejected configuration passes through DRAIN with total 0.
        wr_fire     = dec_valid_o & wr_ready & busy & (wr_cnt_q != total_q);
        wr_en       = wr_fire;
        wr_addr     = wr_base_q + ADDR_W'(wr_cnt_q);
        wr_a0       = dec_doa;
        wr_a1       = dec_dob[5:0];
    end

    // Next-state logic for the sequencer and its configuration/counters.
    always_comb begin
        state_d   = state_q;
        sec_lvl_d = sec_lvl_q;
        total_d   = total_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        rd_cnt_d  = rd_cnt_q + {{(CNT_W-1){1'b0}}, rd_en};
        wr_cnt_d  = wr_cnt_q + {{(CNT_W-1){1'b0}}, wr_fire};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sec_lvl_d = sec_lvl;
                    rd_base_d = rd_base;
                    wr_base_d = wr_base;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    if (cfg_bad) begin
                        // Zero-length run: one cycle in DRAIN, then DONE,
                        // without touching either memory.
                        total_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        total_d = req_total;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (rd_cnt_q == total_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look ahead at the updated count so done follows the last
                // write by exactly one cycle.
                if (wr_cnt_d == total_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-entry read-data FIFO: push on the cycle after a read, pop on accept.
    always_comb begin
        fifo_mem_d  = fifo_mem_q;
        pending_d   = rd_en;
        fifo_wptr_d = fifo_wptr_q ^ push;
        fifo_rptr_d = fifo_rptr_q ^ pop;
        fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            fifo_mem_d[fifo_wptr_q] = rd_data;
        end
    end

    // State, configuration, counter and FIFO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sec_lvl_q   <= '0;
            total_q     <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            rd_base_q   <= '0;
            wr_base_q   <= '0;
            pending_q   <= 1'b0;
            fifo_mem_q  <= '{default: '0};
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sec_lvl_q   <= sec_lvl_d;
            total_q     <= total_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_base_q   <= rd_base_d;
            wr_base_q   <= wr_base_d;
            pending_q   <= pending_d;
            fifo_mem_q  <= fifo_mem_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decomp_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decomp_stream_ctrl
// Description : Self-checking bench for decomp_stream_ctrl with a source RAM,
//               a stallable 5-stage decomposer model and a write logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decomp_stream_ctrl;

    localparam int ADDR_W  = 11;
    localparam int Q       = 8380417;
    localparam int DEC_LAT = 5;
    localparam int LOG_N   = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        sec_lvl;
    logic [3:0]        poly_cnt;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic              busy, done, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       rd_data = '0;
    logic [2:0]        dec_sec_lvl;
    logic [23:0]       dec_di;
    logic              dec_valid_i, dec_ready_i;
    logic [23:0]       dec_doa, dec_dob;
    logic              dec_valid_o, dec_ready_o;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_a0;
    logic [5:0]        wr_a1;
    logic              wr_ready;

    logic              stale_vo;
    int                bp_mode;
    int                cyc = 0;
    int                t0  = 0;
    int                n_chk = 0;
    int                n_err = 0;

    logic [23:0]       src_mem [0:2047];

    // Monitor logs for the current run.
    logic [ADDR_W-1:0] wlog_addr [0:LOG_N-1];
    logic [23:0]       wlog_a0   [0:LOG_N-1];
    logic [5:0]        wlog_a1   [0:LOG_N-1];
    int                wlog_cyc  [0:LOG_N-1];
    logic              busy_log  [0:LOG_N-1];
    int wlog_n, done_n, done_cyc, rd_n, first_rd, first_dvi;
    int ovf, dvi_err, m_fcnt, m_pend, m_fmax;

    decomp_stream_ctrl #(.ADDR_W(11), .N_COEFF(256), .MAX_POLY(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sec_lvl(sec_lvl), .poly_cnt(poly_cnt),
        .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .dec_sec_lvl(dec_sec_lvl), .dec_di(dec_di), .dec_valid_i(dec_valid_i),
        .dec_ready_i(dec_ready_i), .dec_doa(dec_doa), .dec_dob(dec_dob),
        .dec_valid_o(dec_valid_o), .dec_ready_o(dec_ready_o), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_a0(wr_a0), .wr_a1(wr_a1), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference decomposition: r = r1*2*gamma2 + r0 with r0 centred, and the
    // q-1 corner folded to r1=0, r0=-1. Returns {a0, 18 filler bits, a1}.
    function automatic logic [47:0] decompose(input logic [23:0] r, input logic [2:0] lvl);
        int g, m, rr, r0, r1;
        g  = (lvl == 3'd2) ? 95232 : 261888;
        m  = 2 * g;
        rr = int'({8'd0, r});
        r0 = rr % m;
        if (r0 > g) r0 = r0 - m;
        if (rr - r0 == Q - 1) begin
            r1 = 0;
            r0 = r0 - 1;
        end else begin
            r1 = (rr - r0) / m;
        end
        if (r0 < 0) r0 = r0 + Q;
        return {r0[23:0], 18'h2AAAA, r1[5:0]};
    endfunction

    // Source RAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[rd_addr];
    end

    // Decomposer model: the whole pipeline freezes while dec_ready_o is low.
    logic        pv [0:DEC_LAT-1];
    logic [23:0] pa [0:DEC_LAT-1];
    logic [23:0] pb [0:DEC_LAT-1];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEC_LAT; j++) begin
                pv[j] <= 1'b0; pa[j] <= '0; pb[j] <= '0;
            end
        end else if (dec_ready_o) begin
            pv[0] <= dec_valid_i;
            {pa[0], pb[0]} <= decompose(dec_di, dec_sec_lvl);
            for (int j = 1; j < DEC_LAT; j++) begin
                pv[j] <= pv[j-1]; pa[j] <= pa[j-1]; pb[j] <= pb[j-1];
            end
        end
    end
    assign dec_valid_o = pv[DEC_LAT-1] | stale_vo;
    assign dec_doa     = pa[DEC_LAT-1];
    assign dec_dob     = pb[DEC_LAT-1];
    assign dec_ready_i = dec_ready_o;

    // Destination-port grant pattern.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode == 0) wr_ready = 1'b1;
            else if (cyc - t0 < 60) wr_ready = ((cyc - t0) % 2 == 0);
            else wr_ready = ($urandom_range(0, 9) >= 3);
        end
    end

    // Monitor: logs writes/done/reads and tracks FIFO occupancy.
    always @(negedge clk) begin
        int mc, mnxt, mpop;
        mc = cyc - t0;
        if (!rst) begin
            m_fcnt = 0;
            m_pend = 0;
        end else begin
            if (mc >= 0 && mc < LOG_N) busy_log[mc] = busy;
            if (wr_en) begin
                if (wlog_n < LOG_N) begin
                    wlog_addr[wlog_n] = wr_addr;
                    wlog_a0[wlog_n]   = wr_a0;
                    wlog_a1[wlog_n]   = wr_a1;
                    wlog_cyc[wlog_n]  = mc;
                end
                wlog_n++;
            end
            if (done) begin done_n++; done_cyc = mc; end
            if (rd_en) begin rd_n++; if (first_rd < 0) first_rd = mc; end
            if (dec_valid_i && first_dvi < 0) first_dvi = mc;
            if (dec_valid_i !== (m_fcnt != 0)) dvi_err++;
            mpop = (dec_valid_i && dec_ready_i) ? 1 : 0;
            mnxt = m_fcnt + m_pend - mpop;
            if (mnxt > 2) ovf++;
            if (mnxt > m_fmax) m_fmax = mnxt;
            m_fcnt = mnxt;
            m_pend = rd_en ? 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < 2048; a++) src_mem[a] = 24'((a * 7919 + 12345) % Q);
        src_mem[100] = 24'd190464;
        src_mem[101] = 24'd8380416;
    endtask

    task automatic kick(input logic [2:0] lvl, input logic [3:0] pc,
                        input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
        @(posedge clk); #1;
        sec_lvl = lvl; poly_cnt = pc; rd_base = rb; wr_base = wb; start = 1'b1;
        t0 = cyc;
        wlog_n = 0; done_n = 0; done_cyc = -1; rd_n = 0; first_rd = -1;
        first_dvi = -1; ovf = 0; dvi_err = 0; m_fmax = 0;
        for (int b = 0; b < LOG_N; b++) busy_log[b] = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, done_n, 1);
    endtask

    task automatic check_run(input string tag, input logic [2:0] lvl, input int n,
                             input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
        int bad = 0;
        logic [47:0] e;
        chk({tag, "_wr_count"}, wlog_n, n);
        for (int k = 0; k < n && k < LOG_N; k++) begin
            e = decompose(src_mem[ADDR_W'(int'(rb) + k)], lvl);
            if (wlog_addr[k] !== ADDR_W'(int'(wb) + k) || wlog_a0[k] !== e[47:24] ||
                wlog_a1[k] !== e[5:0]) bad++;
        end
        chk({tag, "_wr_stream"}, bad, 0);
        chk({tag, "_fifo_ovf"}, ovf, 0);
        chk({tag, "_dvi_occupancy"}, dvi_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int bad2;
        rst = 1'b0; start = 1'b0; sec_lvl = '0; poly_cnt = '0; rd_base = '0; wr_base = '0;
        stale_vo = 1'b0; bp_mode = 0;
        wlog_n = 0; done_n = 0; done_cyc = -1; rd_n = 0; first_rd = -1; first_dvi = -1;
        ovf = 0; dvi_err = 0; m_fcnt = 0; m_pend = 0; m_fmax = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_dec_valid_i", dec_valid_i, 0);
        chk("rst_dec_sec_lvl", dec_sec_lvl, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Test 1: single polynomial, level 2, latency and first two results.
        fill_pattern();
        kick(3'd2, 4'd1, 11'd100, 11'd700);
        wait_done("t1", 400);
        check_run("t1", 3'd2, 256, 11'd100, 11'd700);
        chk("t1_first_rd_cyc", first_rd, 1);
        chk("t1_first_dvi_cyc", first_dvi, 3);
        chk("t1_first_wr_cyc", wlog_cyc[0], 8);
        chk("t1_last_wr_cyc", wlog_cyc[255], 263);
        chk("t1_done_cyc", done_cyc, 264);
        chk("t1_busy_c1", busy_log[1], 1);
        chk("t1_busy_c263", busy_log[263], 1);
        chk("t1_busy_c265", busy_log[265], 0);
        chk("t1_rd_count", rd_n, 256);
        chk("t1_w0_addr", wlog_addr[0], 700);
        chk("t1_w0_a0", wlog_a0[0], 0);
        chk("t1_w0_a1", wlog_a1[0], 1);
        chk("t1_w1_addr", wlog_addr[1], 701);
        chk("t1_w1_a0", wlog_a0[1], 8380416);
        chk("t1_w1_a1", wlog_a1[1], 0);

        // Test 2: eight polynomials, level 3, constant coefficient.
        for (int a = 0; a < 2048; a++) src_mem[a] = 24'd523776;
        kick(3'd3, 4'd8, 11'd0, 11'd0);
        wait_done("t2", 2400);
        check_run("t2", 3'd3, 2048, 11'd0, 11'd0);
        bad2 = 0;
        for (int k = 0; k < 2048; k++)
            if (wlog_a0[k] !== 24'd0 || wlog_a1[k] !== 6'd1) bad2++;
        chk("t2_all_a0_0_a1_1", bad2, 0);
        chk("t2_last_addr", wlog_addr[2047], 2047);

        // Test 3: backpressure from the destination port.
        fill_pattern();
        bp_mode = 1;
        kick(3'd2, 4'd1, 11'd100, 11'd700);
        wait_done("t3", 3000);
        bp_mode = 0;
        check_run("t3", 3'd2, 256, 11'd100, 11'd700);
        chk("t3_fifo_reached_2", m_fmax, 2);
        chk("t3_rd_count", rd_n, 256);

        // Test 4: rejected polynomial counts, with stale decomposer valid high.
        stale_vo = 1'b1;
        kick(3'd2, 4'd0, 11'd5, 11'd9);
        repeat (6) @(negedge clk);
        chk("t4a_done_cyc", done_cyc, 2);
        chk("t4a_done_once", done_n, 1);
        chk("t4a_no_rd", rd_n, 0);
        chk("t4a_no_wr", wlog_n, 0);
        kick(3'd2, 4'd9, 11'd5, 11'd9);
        repeat (6) @(negedge clk);
        chk("t4b_done_cyc", done_cyc, 2);
        chk("t4b_done_once", done_n, 1);
        chk("t4b_no_rd", rd_n, 0);
        chk("t4b_no_wr", wlog_n, 0);
        stale_vo = 1'b0;
        repeat (2) @(posedge clk);

        // Test 5: a second start during a run is ignored.
        fill_pattern();
        kick(3'd2, 4'd1, 11'd100, 11'd700);
        repeat (49) @(posedge clk);
        #1;
        start = 1'b1; sec_lvl = 3'd3; rd_base = 11'd500; poly_cnt = 4'd2;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t5_sec_lvl_held", dec_sec_lvl, 2);
        wait_done("t5", 400);
        check_run("t5", 3'd2, 256, 11'd100, 11'd700);
        chk("t5_done_cyc", done_cyc, 264);

        // Test 6: reset mid-run, then a fresh run.
        kick(3'd2, 4'd1, 11'd100, 11'd700);
        repeat (99) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rd_en", rd_en, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_abort_no_done", done_n, 0);
        kick(3'd2, 4'd1, 11'd100, 11'd700);
        wait_done("t6", 400);
        check_run("t6", 3'd2, 256, 11'd100, 11'd700);
        chk("t6_first_wr_cyc", wlog_cyc[0], 8);
        chk("t6_done_cyc", done_cyc, 264);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
